// File: rtl/imem_loader_pkg.sv
// Shared types for the boot-time instruction loader.
// Optional checksum stage is enabled with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR,
        LOAD,
        CSUM,
        DONE,
        ERROR
    } state_t;

    localparam int HDR_BYTES = 4;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs four little-endian bytes into a 32-bit word.
// word/word_valid are combinational on the cycle the 4th byte is taken.
module byte_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  data,
    input  logic        valid,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [1:0] LAST = 2'(HDR_BYTES - 1);

    logic [1:0]  cnt;
    logic [23:0] shreg;

    assign word       = {data, shreg};
    assign word_valid = valid && (cnt == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (clear) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (valid) begin
            shreg <= {data, shreg[23:8]};
            cnt   <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed LE image into instruction memory, then releases
// the CPU. Define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int IMEM_DEPTH = 512
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic             reload,
    output logic             mem_en,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_data,
    output logic             cpu_reset,
    output logic             done,
    output logic             error
);

    state_t state, state_n;

    logic [31:0]      count, count_n;
    logic [WIDTH-1:0] idx, idx_n;
    logic [31:0]      word;
    logic             word_valid;
    logic             take;
    logic             clear;
    logic             wr;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum, sum_n;
`endif

    assign take  = rx_valid && rx_ready;
    assign clear = reload && (state == DONE || state == ERROR);

    byte_word_assembler u_asm (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .data       (rx_data),
        .valid      (take),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_n = state;
        count_n = count;
        idx_n   = idx;
        wr      = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_n   = sum;
`endif
        unique case (state)
            HDR: begin
                if (word_valid) begin
                    count_n = word;
                    idx_n   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_n   = '0;
                    if (word == 32'd0)
                        state_n = CSUM;
`else
                    if (word == 32'd0)
                        state_n = DONE;
`endif
                    else if (word > 32'(IMEM_DEPTH))
                        state_n = ERROR;
                    else
                        state_n = LOAD;
                end
            end
            LOAD: begin
                if (word_valid) begin
                    wr    = 1'b1;
                    idx_n = idx + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_n = sum + word;
                    if (idx == WIDTH'(count - 32'd1))
                        state_n = CSUM;
`else
                    if (idx == WIDTH'(count - 32'd1))
                        state_n = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (word_valid)
                    state_n = (word == sum) ? DONE : ERROR;
            end
`endif
            DONE, ERROR: begin
                if (reload) begin
                    state_n = HDR;
                    count_n = '0;
                    idx_n   = '0;
                end
            end
            default: state_n = HDR;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= HDR;
            count     <= '0;
            idx       <= '0;
            rx_ready  <= 1'b1;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            idx      <= idx_n;
            rx_ready <= (state_n == HDR) || (state_n == LOAD) ||
                        (state_n == CSUM);
            mem_en   <= wr;
            if (wr) begin
                mem_addr <= idx;
                mem_data <= WIDTH'(word);
            end
            // Release lags DONE entry so the last write lands first
            cpu_reset <= !(state == DONE && state_n == DONE);
            done      <= (state_n == DONE);
            error     <= (state_n == ERROR);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            sum <= '0;
        else if (clear)
            sum <= '0;
        else
            sum <= sum_n;
    end
`endif

endmodule
